native_port_bram_responder: RTL and testbench

// - Responder (target) side of the LiteDRAM user native port (cmd / wdata / rdata), backed by on-chip block RAM.
// - Stands in for litedram_core in simulation and DDR-less bring-up, so that user-side traffic generators and

---
 rtl/native_port_bram_responder.sv | 169 ++++++++++++++++
 tb/tb_native_port_bram_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/native_port_bram_responder.sv
// Block-RAM responder for the LiteDRAM user native port: byte-masked writes, in-order credit-limited reads.
// Define NATIVE_RESP_PATTERN_FILL_EN to make INIT fill word i with DATA_W/32 copies of the 32-bit value i.
module native_port_bram_responder #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 256,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LATENCY = 2,
  parameter int RDQ_DEPTH  = 4
) (
  input  logic                  user_clk,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_W/8-1:0]   wdata_we,
  input  logic [DATA_W-1:0]     wdata_data,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_W-1:0]     rdata_data
);

  localparam int BYTES  = DATA_W / 8;
  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam int PIPE   = RD_LATENCY - 1;
  localparam int QPTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RDQ_DEPTH + 1);
`ifdef NATIVE_RESP_PATTERN_FILL_EN
  localparam int INIT_CYCLES = WORDS;
`else
  localparam int INIT_CYCLES = 16;
`endif
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {INIT, IDLE, WDATA} state_t;

  state_t                  state;
  logic [INIT_W-1:0]       init_cnt;
  logic [DEPTH_LOG2-1:0]   wdata_addr;
  logic [CNT_W-1:0]        outstanding;
  logic [DATA_W-1:0]       mem [WORDS];

  logic                    cmd_fire;
  logic                    rd_fire;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_addr;
  logic [DEPTH_LOG2-1:0]   rd_addr;
  logic                    push;
  logic                    pop;
  logic [DATA_W-1:0]       push_data;

  // Upper address bits are deliberately dropped so that addresses alias modulo the memory size.
  logic unused_addr;
  assign unused_addr = ^cmd_addr[ADDR_W-1:DEPTH_LOG2];

  // Credits cover both in-flight pipeline reads and queued data, so the queue can never overflow.
  assign cmd_ready   = (state == IDLE) && (outstanding < CNT_W'(RDQ_DEPTH));
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign rd_fire     = cmd_fire && !cmd_we;
  assign wdata_ready = (state == WDATA) || (cmd_fire && cmd_we);
  assign wr_en       = !reset && wdata_valid && wdata_ready;
  assign wr_addr     = (state == WDATA) ? wdata_addr : cmd_addr[DEPTH_LOG2-1:0];
  assign rd_addr     = cmd_addr[DEPTH_LOG2-1:0];

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      wdata_addr <= '0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (cmd_fire && cmd_we && !wdata_valid) begin
            state      <= WDATA;
            wdata_addr <= cmd_addr[DEPTH_LOG2-1:0];
          end
        end
        WDATA: begin
          if (wdata_valid) state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset so they map onto block RAM; contents survive reset.
  always_ff @(posedge user_clk) begin
`ifdef NATIVE_RESP_PATTERN_FILL_EN
    if (!reset && state == INIT)
      mem[init_cnt[DEPTH_LOG2-1:0]] <= {(DATA_W/32){32'(init_cnt)}};
`endif
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wdata_we[i]) mem[wr_addr][8*i +: 8] <= wdata_data[8*i +: 8];
      end
    end
  end

  // The queue write is the last latency stage, so PIPE = RD_LATENCY-1 registers sit in front of it.
  generate
    if (PIPE == 0) begin : g_direct
      assign push      = rd_fire;
      assign push_data = mem[rd_addr];
    end else begin : g_pipe
      logic [PIPE-1:0]   vld;
      logic [DATA_W-1:0] data [PIPE];

      always_ff @(posedge user_clk) begin
        vld[0] <= reset ? 1'b0 : rd_fire;
        if (rd_fire) data[0] <= mem[rd_addr];
        for (int s = 1; s < PIPE; s++) begin
          vld[s]  <= reset ? 1'b0 : vld[s-1];
          data[s] <= data[s-1];
        end
      end

      assign push      = vld[PIPE-1];
      assign push_data = data[PIPE-1];
    end
  endgenerate

  logic [DATA_W-1:0] q [RDQ_DEPTH];
  logic [QPTR_W-1:0] wr_ptr;
  logic [QPTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  q_count;

  assign rdata_valid = (q_count != '0);
  assign rdata_data  = rdata_valid ? q[rd_ptr] : '0;
  assign pop         = rdata_valid && rdata_ready;

  always_ff @(posedge user_clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == QPTR_W'(RDQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == QPTR_W'(RDQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
      case ({rd_fire, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (push) q[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_native_port_bram_responder.sv
// Directed bench for native_port_bram_responder in the default build (pattern fill disabled).
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_native_port_bram_responder;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 256;
  localparam int DEPTH_LOG2 = 8;
  localparam int RD_LATENCY = 2;
  localparam int RDQ_DEPTH  = 4;
  localparam int BYTES      = DATA_W / 8;

  logic                user_clk = 1'b0;
  logic                reset    = 1'b1;
  logic                init_done;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                wdata_valid;
  logic                wdata_ready;
  logic [BYTES-1:0]    wdata_we;
  logic [DATA_W-1:0]   wdata_data;
  logic                rdata_valid;
  logic                rdata_ready;
  logic [DATA_W-1:0]   rdata_data;

  int checks = 0;
  int errors = 0;

  native_port_bram_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LATENCY(RD_LATENCY), .RDQ_DEPTH(RDQ_DEPTH)
  ) dut (
    .user_clk(user_clk), .reset(reset), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata_we(wdata_we), .wdata_data(wdata_data),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_data(rdata_data)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, DATA_W'(obs), DATA_W'(exp));
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    check(tag, DATA_W'(obs), DATA_W'(exp));
  endtask

  function automatic logic [DATA_W-1:0] pat(input int a);
    return {(DATA_W/32){32'hC0DE_0000 | 32'(a)}};
  endfunction

  task automatic step();
    @(posedge user_clk);
    @(negedge user_clk);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 64) begin
      step();
      n++;
    end
  endtask

  // Same-cycle command + data write; also confirms both handshakes are offered.
  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [BYTES-1:0] we, input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a;
    wdata_valid = 1'b1; wdata_we = we; wdata_data = d;
    #1;
    check_bit("wr_cmd_ready", cmd_ready, 1'b1);
    check_bit("wr_wdata_ready", wdata_ready, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_we = 1'b0; wdata_valid = 1'b0;
  endtask

  // Single read with an empty queue: data must appear exactly RD_LATENCY cycles after acceptance.
  task automatic read_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a;
    #1;
    check_bit({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    check_bit({tag, "_early_valid"}, rdata_valid, 1'b0);
    step();
    check_bit({tag, "_valid"}, rdata_valid, 1'b1);
    check({tag, "_data"}, rdata_data, exp);
    rdata_ready = 1'b1;
    step();
    rdata_ready = 1'b0;
    check_bit({tag, "_drained"}, rdata_valid, 1'b0);
  endtask

  localparam logic [DATA_W-1:0] D2 =
    256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0003;
  localparam logic [BYTES-1:0] ALL = '1;

  initial begin
    int n;
    int issued;
    int returned;
    logic fire;
    logic popped;
    logic [DATA_W-1:0] all55;
    logic [DATA_W-1:0] all_aa;
    logic [DATA_W-1:0] merged;

    all55  = {BYTES{8'h55}};
    all_aa = {BYTES{8'hAA}};
    merged = {{(BYTES-1){8'h55}}, 8'hAA};

    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    wdata_valid = 1'b0; wdata_we = '0; wdata_data = '0;
    rdata_ready = 1'b0;
    reset = 1'b1;
    repeat (3) step();

    check_bit("rst_init_done", init_done, 1'b0);
    check_bit("rst_cmd_ready", cmd_ready, 1'b0);
    check_bit("rst_wdata_ready", wdata_ready, 1'b0);
    check_bit("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_rdata_data", rdata_data, '0);

    // INIT lasts 16 cycles; init_done is first seen 16 edges after the last reset edge.
    reset = 1'b0;
    wait_init(n);
    check_int("init_cycles", n, 16);
    check_bit("idle_cmd_ready", cmd_ready, 1'b1);

    // Full write then read-after-write on the next cycle.
    write_word(24'd3, ALL, D2);
    read_word(24'd3, D2, "raw");

    // Stray write data without a command must not write anything.
    cmd_valid = 1'b0; cmd_addr = 24'd3;
    wdata_valid = 1'b1; wdata_we = ALL; wdata_data = all_aa;
    #1;
    check_bit("stray_wdata_ready", wdata_ready, 1'b0);
    step();
    wdata_valid = 1'b0;
    read_word(24'd3, D2, "stray");

    // Byte masking, empty mask, address aliasing.
    write_word(24'd7, ALL, all55);
    write_word(24'd7, 32'h0000_0001, all_aa);
    read_word(24'd7, merged, "mask");
    write_word(24'd7, '0, pat(99));
    read_word(24'd7, merged, "nomask");
    write_word(24'h000107, ALL, pat(7));
    read_word(24'd7, pat(7), "alias_lo");
    read_word(24'h000207, pat(7), "alias_hi");

    // Credit limit: six reads with rdata held off; only four may be accepted.
    for (int a = 10; a < 16; a++) write_word(ADDR_W'(a), ALL, pat(a));
    issued = 0;
    returned = 0;
    rdata_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      cmd_valid = (issued < 6); cmd_we = 1'b0; cmd_addr = ADDR_W'(10 + issued);
      #1;
      fire = cmd_valid && cmd_ready;
      step();
      if (fire) issued++;
    end
    check_int("credit_issued", issued, 4);
    cmd_valid = 1'b1; cmd_addr = ADDR_W'(10 + issued);
    #1;
    check_bit("credit_cmd_ready", cmd_ready, 1'b0);
    check_bit("credit_hold_valid", rdata_valid, 1'b1);
    check("credit_hold_data", rdata_data, pat(10));

    rdata_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && returned < 6; cyc++) begin
      cmd_valid = (issued < 6); cmd_addr = ADDR_W'(10 + issued);
      #1;
      fire   = cmd_valid && cmd_ready;
      popped = rdata_valid && rdata_ready;
      if (popped) check($sformatf("order_%0d", returned), rdata_data, pat(10 + returned));
      step();
      if (fire) issued++;
      if (popped) returned++;
    end
    rdata_ready = 1'b0; cmd_valid = 1'b0;
    check_int("order_returned", returned, 6);
    check_int("order_issued", issued, 6);

    // Write command with data three cycles late; a read waits behind it.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'd20; wdata_valid = 1'b0;
    #1;
    check_bit("wd_cmd_ready", cmd_ready, 1'b1);
    step();
    cmd_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        wdata_valid = 1'b1; wdata_we = ALL; wdata_data = pat(55);
      end
      #1;
      check_bit($sformatf("wd_block_%0d", k), cmd_ready, 1'b0);
      check_bit($sformatf("wd_ready_%0d", k), wdata_ready, 1'b1);
      step();
    end
    wdata_valid = 1'b0;
    #1;
    check_bit("wd_next_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    step();
    check_bit("wd_read_valid", rdata_valid, 1'b1);
    check("wd_read_data", rdata_data, pat(55));
    rdata_ready = 1'b1;
    step();
    rdata_ready = 1'b0;

    // Reset with three reads outstanding and a half-done write.
    write_word(24'd40, ALL, pat(40));
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = ADDR_W'(40 + k);
      step();
    end
    cmd_we = 1'b1; cmd_addr = 24'd40; wdata_valid = 1'b0;
    #1;
    check_bit("rst6_wr_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_we = 1'b0;
    reset = 1'b1;
    wdata_valid = 1'b1; wdata_we = ALL; wdata_data = pat(666);
    step();
    check_bit("rst6_rdata_valid", rdata_valid, 1'b0);
    check_bit("rst6_init_done", init_done, 1'b0);
    check_bit("rst6_cmd_ready", cmd_ready, 1'b0);
    check("rst6_rdata_data", rdata_data, '0);
    reset = 1'b0;
    wait_init(n);
    wdata_valid = 1'b0;
    check_int("rst6_init_cycles", n, 16);
    check_bit("rst6_no_stale", rdata_valid, 1'b0);
    read_word(24'd40, pat(40), "keep40");
    read_word(24'd3, D2, "keep3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
